// File: rtl/lock_sequencer.sv
// rtl/lock_sequencer.sv - boat-lock chamber sequencer: request arbitration, gate and water-level control
module lock_sequencer #(
    parameter int LEVEL_MAX   = 8,
    parameter int STEP_CYCLES = 2,
    parameter int GATE_TICKS  = 4,
    parameter int TIMEOUT     = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_outer,
    input  logic       req_inner,
    input  logic       boat_in,
    output logic       grant_outer,
    output logic       grant_inner,
    output logic       outer_open,
    output logic       inner_open,
    output logic       filling,
    output logic       draining,
    output logic [3:0] level,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        ENTER = 3'd2,
        SHIFT = 3'd3,
        EXIT  = 3'd4
    } state_t;

    localparam int SW   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int GMAX = (TIMEOUT > GATE_TICKS) ? TIMEOUT : GATE_TICKS;
    localparam int GW   = $clog2(GMAX + 1);

    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_TICKS - 1);
    localparam logic [GW-1:0] TOUT_LAST = GW'(TIMEOUT - 1);
    localparam logic [3:0]    LVL_TOP   = 4'(LEVEL_MAX);

    // Side encoding: 0 = outer (low water), 1 = inner (high water).
    state_t          state_q, state_d;
    logic            side_q, side_d;
    logic            last_q, last_d;
    logic [3:0]      level_q, level_d;
    logic [SW-1:0]   step_q, step_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;

    logic            grant_outer_q, grant_outer_d;
    logic            grant_inner_q, grant_inner_d;
    logic            outer_open_q, outer_open_d;
    logic            inner_open_q, inner_open_d;
    logic            filling_q, filling_d;
    logic            draining_q, draining_d;
    logic            busy_q, busy_d;

    logic            pick_inner;
    logic [3:0]      tgt_now;
    logic [3:0]      tgt_next;
    logic            moving_next;

    function automatic logic [3:0] target_of(input logic inner_side);
        return inner_side ? LVL_TOP : 4'd0;
    endfunction

    always_comb begin
        state_d       = state_q;
        side_d        = side_q;
        last_d        = last_q;
        level_d       = level_q;
        step_d        = step_q;
        gcnt_d        = gcnt_q;
        grant_outer_d = 1'b0;
        grant_inner_d = 1'b0;
        pick_inner    = req_inner & (~req_outer | ~last_q);
        tgt_now       = target_of((state_q == PREP) ? side_q : ~side_q);

        case (state_q)
            IDLE: begin
                if (req_outer || req_inner) begin
                    side_d        = pick_inner;
                    grant_inner_d = pick_inner;
                    grant_outer_d = ~pick_inner;
                    state_d       = PREP;
                end
            end
            PREP, SHIFT: begin
                if (level_q != tgt_now) begin
                    if (step_q == STEP_LAST) begin
                        step_d  = '0;
                        level_d = (tgt_now > level_q) ? level_q + 4'd1 : level_q - 4'd1;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
                // Leaving on the edge the target is reached keeps the gate from idling a cycle.
                if (level_d == tgt_now) begin
                    state_d = (state_q == PREP) ? ENTER : EXIT;
                end
            end
            ENTER: begin
                if (gcnt_q >= GATE_LAST && boat_in) begin
                    state_d = SHIFT;
                end else if (gcnt_q >= TOUT_LAST) begin
                    state_d = IDLE;
                    last_d  = side_q;
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            EXIT: begin
                if (gcnt_q >= GATE_LAST && !boat_in) begin
                    state_d = IDLE;
                    last_d  = side_q;
                end else if (gcnt_q < GATE_LAST) begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            step_d = '0;
            gcnt_d = '0;
        end

        // Outputs are derived from the next state so they register alongside it.
        moving_next  = (state_d == PREP) || (state_d == SHIFT);
        tgt_next     = target_of((state_d == PREP) ? side_d : ~side_d);
        outer_open_d = ((state_d == ENTER) && !side_d) || ((state_d == EXIT) && side_d);
        inner_open_d = ((state_d == ENTER) && side_d) || ((state_d == EXIT) && !side_d);
        filling_d    = moving_next && (tgt_next > level_d);
        draining_d   = moving_next && (tgt_next < level_d);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            side_q        <= 1'b0;
            last_q        <= 1'b1;
            level_q       <= 4'd0;
            step_q        <= '0;
            gcnt_q        <= '0;
            grant_outer_q <= 1'b0;
            grant_inner_q <= 1'b0;
            outer_open_q  <= 1'b0;
            inner_open_q  <= 1'b0;
            filling_q     <= 1'b0;
            draining_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            side_q        <= side_d;
            last_q        <= last_d;
            level_q       <= level_d;
            step_q        <= step_d;
            gcnt_q        <= gcnt_d;
            grant_outer_q <= grant_outer_d;
            grant_inner_q <= grant_inner_d;
            outer_open_q  <= outer_open_d;
            inner_open_q  <= inner_open_d;
            filling_q     <= filling_d;
            draining_q    <= draining_d;
            busy_q        <= busy_d;
        end
    end

    assign grant_outer = grant_outer_q;
    assign grant_inner = grant_inner_q;
    assign outer_open  = outer_open_q;
    assign inner_open  = inner_open_q;
    assign filling     = filling_q;
    assign draining    = draining_q;
    assign level       = level_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// tb/tb_lock_sequencer.sv - directed and random checks for lock_sequencer
module tb_lock_sequencer;

    logic       clk;
    logic       rst_n;
    logic       req_outer;
    logic       req_inner;
    logic       boat_in;
    logic       grant_outer;
    logic       grant_inner;
    logic       outer_open;
    logic       inner_open;
    logic       filling;
    logic       draining;
    logic [3:0] level;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;
    logic prev_busy = 1'b0;

    lock_sequencer #(
        .LEVEL_MAX  (8),
        .STEP_CYCLES(2),
        .GATE_TICKS (4),
        .TIMEOUT    (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_outer  (req_outer),
        .req_inner  (req_inner),
        .boat_in    (boat_in),
        .grant_outer(grant_outer),
        .grant_inner(grant_inner),
        .outer_open (outer_open),
        .inner_open (inner_open),
        .filling    (filling),
        .draining   (draining),
        .level      (level),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sel(input int w);
        case (w)
            0:       return outer_open;
            1:       return inner_open;
            2:       return filling;
            3:       return draining;
            default: return busy;
        endcase
    endfunction

    task automatic count_while(input int w, output int n);
        n = 0;
        while (sel(w) && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic wait_high(input string tag, input int w);
        int n;
        n = 0;
        while (!sel(w) && n < 200) begin
            n++;
            step();
        end
        if (n >= 200) check_eq(tag, 0, 1);
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        req_outer = 1'b0;
        req_inner = 1'b0;
        boat_in   = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Invariants and grant legality, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("invariants",
                     int'({outer_open & inner_open,
                           filling & draining,
                           (filling | draining) & (outer_open | inner_open),
                           outer_open && (level != 4'd0),
                           inner_open && (level != 4'd8),
                           level > 4'd8,
                           grant_outer & grant_inner}), 0);
            check_eq("grant_while_busy", int'((grant_outer | grant_inner) & prev_busy), 0);
            prev_busy = busy;
        end else begin
            prev_busy = 1'b0;
        end
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        req_outer = 1'b0;
        req_inner = 1'b0;
        boat_in   = 1'b0;
        step();
        step();
        check_eq("reset_level", int'(level), 0);
        check_eq("reset_busy", int'(busy), 0);
        check_eq("reset_outs", int'({grant_outer, grant_inner, outer_open, inner_open, filling, draining}), 0);

        // 1: single outer passage
        rst_n     = 1'b1;
        req_outer = 1'b1;
        step();
        check_eq("t1_grant_outer", int'(grant_outer), 1);
        check_eq("t1_busy", int'(busy), 1);
        req_outer = 1'b0;
        step();
        check_eq("t1_grant_pulse", int'(grant_outer), 0);
        check_eq("t1_prep_one_cycle", int'(outer_open), 1);
        n = 0;
        while (outer_open && n < 200) begin
            n++;
            if (n == 2) boat_in = 1'b1;
            step();
        end
        check_eq("t1_outer_open_cycles", n, 4);
        count_while(2, n);
        check_eq("t1_fill_cycles", n, 16);
        check_eq("t1_level_top", int'(level), 8);
        check_eq("t1_inner_open", int'(inner_open), 1);
        boat_in = 1'b0;
        count_while(1, n);
        check_eq("t1_inner_open_cycles", n, 4);
        check_eq("t1_final_level", int'(level), 8);
        check_eq("t1_final_busy", int'(busy), 0);

        // 2: tie from reset, outer first, then inner
        reset_dut();
        req_outer = 1'b1;
        req_inner = 1'b1;
        step();
        check_eq("t2_first_outer", int'({grant_outer, grant_inner}), 2);
        step();
        boat_in = 1'b1;
        count_while(0, n);
        check_eq("t2_outer_cycles", n, 4);
        count_while(2, n);
        check_eq("t2_fill_cycles", n, 16);
        boat_in = 1'b0;
        count_while(1, n);
        check_eq("t2_idle", int'(busy), 0);
        step();
        check_eq("t2_then_inner", int'({grant_outer, grant_inner}), 1);
        req_outer = 1'b0;
        req_inner = 1'b0;
        step();
        check_eq("t2_prep_skip", int'(inner_open), 1);
        boat_in = 1'b1;
        count_while(1, n);
        check_eq("t2_drain_start", int'(draining), 1);
        count_while(3, n);
        check_eq("t2_drain_cycles", n, 16);
        check_eq("t2_outer_at_zero", int'({outer_open, level}), 16);
        boat_in = 1'b0;
        count_while(0, n);
        check_eq("t2_done", int'({busy, level}), 0);

        // 3: inner request from level 0
        req_inner = 1'b1;
        step();
        check_eq("t3_grant_inner", int'(grant_inner), 1);
        check_eq("t3_filling_prep", int'({filling, draining, inner_open}), 4);
        req_inner = 1'b0;
        count_while(2, n);
        check_eq("t3_fill_cycles", n, 16);
        check_eq("t3_inner_at_top", int'({inner_open, level}), 24);
        boat_in = 1'b1;
        count_while(1, n);
        count_while(3, n);
        boat_in = 1'b0;
        count_while(0, n);
        check_eq("t3_done", int'({busy, level}), 0);

        // 4: entry timeout
        req_outer = 1'b1;
        step();
        check_eq("t4_grant_outer", int'(grant_outer), 1);
        req_outer = 1'b0;
        step();
        check_eq("t4_no_fill", int'(filling), 0);
        count_while(0, n);
        check_eq("t4_timeout_cycles", n, 32);
        check_eq("t4_abort_idle", int'({busy, level, filling}), 0);
        req_outer = 1'b1;
        req_inner = 1'b1;
        step();
        check_eq("t4_tie_inner", int'({grant_outer, grant_inner}), 1);
        req_outer = 1'b0;
        req_inner = 1'b0;

        // 5: asynchronous reset mid-shift
        reset_dut();
        req_outer = 1'b1;
        step();
        req_outer = 1'b0;
        step();
        boat_in = 1'b1;
        count_while(0, n);
        n = 0;
        while (level != 4'd5 && n < 200) begin
            n++;
            step();
        end
        check_eq("t5_mid_shift", int'({filling, level}), 21);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_async_outs", int'({grant_outer, grant_inner, outer_open, inner_open, filling, draining, busy}), 0);
        check_eq("t5_async_level", int'(level), 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        boat_in   = 1'b0;
        req_outer = 1'b1;
        req_inner = 1'b1;
        step();
        check_eq("t5_tie_outer", int'({grant_outer, grant_inner}), 2);
        req_outer = 1'b0;
        req_inner = 1'b0;
        wait_high("t5_reach_open", 0);

        // 6: random traffic, invariants checked by the monitor
        for (int i = 0; i < 10000; i++) begin
            req_outer = ($urandom_range(0, 3) == 0);
            req_inner = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) boat_in = ~boat_in;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
